lock_sequencer: RTL and testbench



---
 rtl/lock_sequencer_if.sv | 33 +++
 rtl/lock_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lock_sequencer_if
// Brief    : Keypad-side inputs and status outputs of the lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface lock_sequencer_if #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_FAILS = 3
);
    logic                              key_valid;
    logic [DIGIT_W-1:0]                key_digit;
    logic                              clear_req;
    logic [DIGITS*DIGIT_W-1:0]         code_word;
    logic                              check_en;
    logic                              unlocked;
    logic                              locked_out;
    logic                              restart;
    logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt;
    logic [$clog2(DIGITS+1)-1:0]       digit_cnt;

    modport master (
        output key_valid, key_digit, clear_req, code_word,
        input  check_en, unlocked, locked_out, restart, fail_cnt, digit_cnt
    );

    modport slave (
        input  key_valid, key_digit, clear_req, code_word,
        output check_en, unlocked, locked_out, restart, fail_cnt, digit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lock_sequencer
// Brief    : Keypad entry buffer, code check, open/fail/lockout sequencing and
//            downstream restart. ENTRY_TIMEOUT_EN adds an inactivity timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lock_sequencer #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int TIMEOUT_CYC = 5000
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    lock_sequencer_if.slave  bus
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int DC_W   = $clog2(DIGITS + 1);
    localparam int FC_W   = $clog2(MAX_FAILS + 1);
    localparam int LK_W   = $clog2(LOCKOUT_CYC + 1);

    localparam logic [DC_W-1:0] C_DIGITS    = DC_W'(DIGITS);
    localparam logic [FC_W-1:0] C_MAX_FAILS = FC_W'(MAX_FAILS);
    localparam logic [LK_W-1:0] C_LK_LOAD   = LK_W'(LOCKOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    if ((MAX_FAILS < 1) || (LOCKOUT_CYC < 2) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("lock_sequencer: MAX_FAILS>=1, LOCKOUT_CYC>=2, TIMEOUT_CYC>=1 required");
    end

    state_t            state_q,      state_d;
    logic [CODE_W-1:0] buf_q,        buf_d;
    logic [DC_W-1:0]   digit_cnt_q,  digit_cnt_d;
    logic [FC_W-1:0]   fail_cnt_q,   fail_cnt_d;
    logic [LK_W-1:0]   lk_cnt_q,     lk_cnt_d;
    logic              check_en_q,   check_en_d;
    logic              unlocked_q,   unlocked_d;
    logic              locked_out_q, locked_out_d;
    logic              restart_q,    restart_d;

    logic [CODE_W-1:0] w_buf_shift;
    logic [DC_W-1:0]   w_acc_cnt;
    logic [FC_W-1:0]   w_fail_inc;
    logic              w_key_acc;

`ifdef ENTRY_TIMEOUT_EN
    localparam int              TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        digit_cnt_d  = digit_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        lk_cnt_d     = lk_cnt_q;
        check_en_d   = 1'b0;
        unlocked_d   = 1'b0;
        locked_out_d = 1'b0;
        restart_d    = 1'b0;
        w_key_acc    = 1'b0;

        w_buf_shift = (buf_q << DIGIT_W) | CODE_W'(bus.key_digit);
        // IDLE always holds an empty buffer, so an accepted key there counts as the first digit
        w_acc_cnt   = (state_q == S_IDLE) ? DC_W'(1) : digit_cnt_q + DC_W'(1);
        w_fail_inc  = (fail_cnt_q == C_MAX_FAILS) ? fail_cnt_q : fail_cnt_q + FC_W'(1);

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if ((state_q == S_ENTRY) && bus.clear_req) begin
                    state_d     = S_IDLE;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                end else if (bus.key_valid) begin
                    w_key_acc   = 1'b1;
                    buf_d       = w_buf_shift;
                    digit_cnt_d = w_acc_cnt;
                    if (w_acc_cnt == C_DIGITS) begin
                        state_d    = S_CHECK;
                        check_en_d = 1'b1;
                    end else begin
                        state_d    = S_ENTRY;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if ((state_q == S_ENTRY) && (to_cnt_q == C_TO_LAST)) begin
                    state_d     = S_IDLE;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                end
`endif
            end

            S_CHECK: begin
                if (buf_q == bus.code_word) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                    unlocked_d = 1'b1;
                end else begin
                    fail_cnt_d  = w_fail_inc;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                    if (w_fail_inc == C_MAX_FAILS) begin
                        state_d      = S_LOCKOUT;
                        locked_out_d = 1'b1;
                        lk_cnt_d     = C_LK_LOAD;
                    end else begin
                        state_d   = S_FAIL;
                        restart_d = 1'b1;
                    end
                end
            end

            S_OPEN: begin
                if (bus.clear_req) begin
                    state_d     = S_IDLE;
                    buf_d       = '0;
                    digit_cnt_d = '0;
                    restart_d   = 1'b1;
                end else begin
                    unlocked_d  = 1'b1;
                end
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            S_LOCKOUT: begin
                if (lk_cnt_q == '0) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                    restart_d  = 1'b1;
                end else begin
                    lk_cnt_d     = lk_cnt_q - LK_W'(1);
                    locked_out_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                buf_d       = '0;
                digit_cnt_d = '0;
            end
        endcase

`ifdef ENTRY_TIMEOUT_EN
        // Reloads on every accepted key and stays cleared whenever the next state is not ENTRY
        if ((state_d == S_ENTRY) && !w_key_acc) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            lk_cnt_q     <= '0;
            check_en_q   <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            restart_q    <= 1'b1;
`ifdef ENTRY_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            digit_cnt_q  <= digit_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            lk_cnt_q     <= lk_cnt_d;
            check_en_q   <= check_en_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
            restart_q    <= restart_d;
`ifdef ENTRY_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign bus.check_en   = check_en_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.locked_out = locked_out_q;
    assign bus.restart    = restart_q;
    assign bus.fail_cnt   = fail_cnt_q;
    assign bus.digit_cnt  = digit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// Testbench for lock_sequencer: scoreboard of expected check outcomes plus
// directed checks of clear, lockout length, reset and the optional timeout.
module tb_lock_sequencer;
    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int MAX_FAILS   = 3;
    localparam int LOCKOUT_CYC = 40;
    localparam int TIMEOUT_CYC = 20;
    localparam logic [15:0] CODE = 16'h1234;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    lock_sequencer_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAILS(MAX_FAILS)) bus_if ();

    lock_sequencer #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_FAILS   (MAX_FAILS),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_if)
    );

    typedef struct {
        logic unl;
        logic lko;
        logic rst;
        int   fc;
        int   dc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = d;
        tick();
        bus_if.key_valid = 1'b0;
    endtask

    task automatic collect();
        exp_t e;
        int waited = 0;
        while (bus_if.check_en !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        chk("check_latency", waited, 0);
        chk("check_en_seen", bus_if.check_en, 1);
        chk("unlocked_in_check", bus_if.unlocked, 0);
        tick();
        chk("check_en_one_cycle", bus_if.check_en, 0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("unlocked", bus_if.unlocked, e.unl);
            chk("locked_out", bus_if.locked_out, e.lko);
            chk("restart", bus_if.restart, e.rst);
            chk("fail_cnt", bus_if.fail_cnt, e.fc);
            chk("digit_cnt", bus_if.digit_cnt, e.dc);
            if (e.rst) begin
                tick();
                chk("fail_restart_fall", bus_if.restart, 0);
                chk("fail_digit_cnt", bus_if.digit_cnt, 0);
                chk("fail_unlocked", bus_if.unlocked, 0);
            end
        end
    endtask

    task automatic enter_code(input logic [15:0] keys);
        exp_t e;
        for (int i = 0; i < DIGITS - 1; i++) press(keys[15 - 4*i -: 4]);
        if (keys == CODE) begin
            m_fail = 0;
            e = '{1'b1, 1'b0, 1'b0, 0, DIGITS};
        end else begin
            if (m_fail < MAX_FAILS) m_fail++;
            if (m_fail == MAX_FAILS) e = '{1'b0, 1'b1, 1'b0, m_fail, 0};
            else                     e = '{1'b0, 1'b0, 1'b1, m_fail, 0};
        end
        sb_q.push_back(e);
        press(keys[3:0]);
        collect();
    endtask

    task automatic open_clear();
        bus_if.clear_req = 1'b1;
        tick();
        bus_if.clear_req = 1'b0;
        chk("clr_unlocked", bus_if.unlocked, 0);
        chk("clr_restart", bus_if.restart, 1);
        chk("clr_digit_cnt", bus_if.digit_cnt, 0);
        tick();
        chk("clr_restart_pulse", bus_if.restart, 0);
    endtask

    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        #1;
        chk({tag, "_unlocked"}, bus_if.unlocked, 0);
        chk({tag, "_locked_out"}, bus_if.locked_out, 0);
        chk({tag, "_check_en"}, bus_if.check_en, 0);
        chk({tag, "_restart"}, bus_if.restart, 1);
        chk({tag, "_fail_cnt"}, bus_if.fail_cnt, 0);
        chk({tag, "_digit_cnt"}, bus_if.digit_cnt, 0);
        tick();
        RST_N = 1'b1;
        #1;
        chk({tag, "_restart_held"}, bus_if.restart, 1);
        tick();
        chk({tag, "_restart_fall"}, bus_if.restart, 0);
        m_fail = 0;
    endtask

    initial begin
        int cnt;
        int dc_bad;
        int guard;
        bus_if.key_valid = 1'b0;
        bus_if.key_digit = '0;
        bus_if.clear_req = 1'b0;
        bus_if.code_word = CODE;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_restart", bus_if.restart, 1);
        chk("rst_unlocked", bus_if.unlocked, 0);
        chk("rst_locked_out", bus_if.locked_out, 0);
        chk("rst_fail_cnt", bus_if.fail_cnt, 0);
        chk("rst_digit_cnt", bus_if.digit_cnt, 0);
        RST_N = 1'b1;
        #1;
        chk("rel_restart_held", bus_if.restart, 1);
        tick();
        chk("rel_restart_fall", bus_if.restart, 0);

        // Correct entry, then relock
        enter_code(16'h1234);
        open_clear();

        // Single wrong entry
        enter_code(16'h1235);

        // Clear beats key in the same cycle
        press(4'h1);
        press(4'h2);
        chk("entry_digit_cnt", bus_if.digit_cnt, 2);
        bus_if.clear_req = 1'b1;
        bus_if.key_valid = 1'b1;
        bus_if.key_digit = 4'h3;
        tick();
        bus_if.clear_req = 1'b0;
        bus_if.key_valid = 1'b0;
        chk("clr_entry_digit_cnt", bus_if.digit_cnt, 0);
        chk("clr_entry_fail_cnt", bus_if.fail_cnt, m_fail);
        chk("clr_entry_restart", bus_if.restart, 0);
        bus_if.clear_req = 1'b1;
        tick();
        bus_if.clear_req = 1'b0;
        chk("idle_clear_ignored_restart", bus_if.restart, 0);
        enter_code(16'h1234);
        open_clear();

        // Three wrong entries reach lockout
        enter_code(16'h1111);
        enter_code(16'h2222);
        enter_code(16'h9999);
        cnt    = 1;
        dc_bad = 0;
        guard  = 0;
        while (guard < LOCKOUT_CYC + 10) begin
            bus_if.key_valid = guard[0];
            bus_if.key_digit = 4'h1;
            bus_if.clear_req = guard[1];
            tick();
            guard++;
            if (bus_if.locked_out !== 1'b1) break;
            cnt++;
            if (bus_if.digit_cnt !== '0) dc_bad++;
        end
        bus_if.key_valid = 1'b0;
        bus_if.clear_req = 1'b0;
        chk("lockout_len", cnt, LOCKOUT_CYC);
        chk("lockout_keys_ignored", dc_bad, 0);
        chk("lockout_exit_restart", bus_if.restart, 1);
        chk("lockout_exit_fail_cnt", bus_if.fail_cnt, 0);
        chk("lockout_exit_digit_cnt", bus_if.digit_cnt, 0);
        m_fail = 0;
        tick();
        chk("lockout_restart_pulse", bus_if.restart, 0);

        // Reset mid-ENTRY with a pending failure count
        enter_code(16'h4321);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        chk("pre_reset_digit_cnt", bus_if.digit_cnt, 3);
        chk("pre_reset_fail_cnt", bus_if.fail_cnt, 1);
        do_reset("rst_entry");

        // Reset mid-LOCKOUT
        enter_code(16'h0000);
        enter_code(16'h0001);
        enter_code(16'h0002);
        repeat (5) tick();
        chk("mid_lockout", bus_if.locked_out, 1);
        do_reset("rst_lockout");
        enter_code(16'h1234);
        open_clear();

`ifdef ENTRY_TIMEOUT_EN
        enter_code(16'h5555);
        press(4'h1);
        repeat (TIMEOUT_CYC - 1) tick();
        chk("to_before_expiry", bus_if.digit_cnt, 1);
        tick();
        chk("to_expired_digit_cnt", bus_if.digit_cnt, 0);
        chk("to_fail_cnt_kept", bus_if.fail_cnt, 1);
        chk("to_no_restart", bus_if.restart, 0);
        for (int i = 0; i < DIGITS - 1; i++) begin
            press(CODE[15 - 4*i -: 4]);
            repeat (TIMEOUT_CYC - 2) @(posedge CLK);
            #1;
        end
        sb_q.push_back('{1'b1, 1'b0, 1'b0, 0, DIGITS});
        m_fail = 0;
        press(CODE[3:0]);
        collect();
        open_clear();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
